pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Drives the PLL side of the PLL status interconnect: generates `pll_powerdown` and `mcgb_rst` and qualifies the raw `pll_locked` before consumers see it.
- Sequence: power down the PLL, wait for a stable lock, release the master CGB reset, then report a qualified lock.
- Also handles lock timeouts with bounded retries, lock loss, and powerdown requests from the two channel consumers (a/b).

Parameters:
- PD_HOLD_CYCLES, 100: cycles `pll_powerdown` is held high on each powerdown entry.
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-lock-high cycles required before the lock is accepted.
- LOCK_TIMEOUT_CYCLES, 65536: maximum cycles in WAIT_LOCK before a retry.
- MCGB_DELAY_CYCLES, 16: cycles between lock acceptance and `mcgb_rst` release.
- MAX_RETRIES, 3: timeouts tolerated before entering FAIL.
- CNT_W, 17: shared down-counter width; must hold max(all *_CYCLES)-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pll_locked  in  1  raw PLL lock, asynchronous to clk
- pll_powerdown_a  in  1  powerdown request, consumer a (level)
- pll_powerdown_b  in  1  powerdown request, consumer b (level)
- clear_sticky  in  1  single-cycle pulse; clears `lock_lost`
- pll_powerdown  out  1  PLL powerdown
- mcgb_rst  out  1  master CGB reset
- pll_locked_q  out  1  qualified lock to consumers
- lock_lost  out  1  sticky: lock dropped while in LOCKED
- seq_fail  out  1  retries exhausted
- retry_cnt  out  2  timeouts since last clean start, saturating

Behaviour:
- Reset is asynchronous, active-high; only clk is used.
- Reset values:
  - state = PWRDN.
  - `pll_powerdown` = 1, `mcgb_rst` = 1.
  - `pll_locked_q` = 0, `lock_lost` = 0, `seq_fail` = 0, `retry_cnt` = 0.
  - Synchronizer flops = 0.
- Synchronization:
  - `pll_locked` passes through a 2-flop synchronizer (`lk_s`).
  - `req` = `pll_powerdown_a` | `pll_powerdown_b`, through a 2-flop synchronizer (`req_s`).
- Counter rule:
  - On state entry the counter loads N-1.
  - The exit condition is counter==0, so the timed state lasts exactly N cycles.
- All outputs are registered and reflect the current state.
- PWRDN (`pll_powerdown`=1, `mcgb_rst`=1, `pll_locked_q`=0):
  - Counts PD_HOLD_CYCLES, then goes to WAIT_LOCK.
  - While `req_s`=1, the counter reloads every cycle, so the hold extends until PD_HOLD_CYCLES after `req_s` falls.
- WAIT_LOCK (`pll_powerdown`=0, `mcgb_rst`=1):
  - A stable counter reloads whenever `lk_s`=0.
  - Lock accepted when `lk_s` has been 1 for LOCK_STABLE_CYCLES consecutive cycles -> MCGB_WAIT.
  - A separate timeout counter runs from entry. At LOCK_TIMEOUT_CYCLES without acceptance:
    - `retry_cnt`++ (saturating at 3).
    - If the new value > MAX_RETRIES -> FAIL; else -> PWRDN.
  - If acceptance and timeout occur in the same cycle, acceptance wins.
- MCGB_WAIT (`pll_powerdown`=0, `mcgb_rst`=1):
  - Counts MCGB_DELAY_CYCLES, then -> LOCKED.
  - `lk_s`=0 at any point -> PWRDN (no retry increment).
- LOCKED (`pll_powerdown`=0, `mcgb_rst`=0, `pll_locked_q`=1):
  - `lk_s`=0 for one cycle -> PWRDN, with `lock_lost` set and `retry_cnt` cleared.
  - `pll_locked_q` is 0 on the cycle after `lk_s` is sampled low.
- FAIL (`pll_powerdown`=1, `mcgb_rst`=1, `seq_fail`=1):
  - Leaves only on a `req_s` rising edge (-> PWRDN, `retry_cnt` cleared, `seq_fail` cleared) or on reset.
- `req_s`=1 in WAIT_LOCK, MCGB_WAIT or LOCKED -> PWRDN immediately, `retry_cnt` cleared, `lock_lost` not set.
- `lock_lost`:
  - Cleared by `clear_sticky`.
  - If set and clear occur in the same cycle, set wins.
- Lock glitches shorter than one clk period may be missed; the PLL guarantees lock-drop pulses ≥ 2 clk periods.

Optional Feature:
- Macro: PLL_SEQ_LOSS_COUNT_EN.
- When defined:
  - Adds output `lock_loss_count` [7:0]: saturating count of LOCKED->PWRDN transitions caused by lock loss.
  - Reset to 0; cleared by `clear_sticky`.
  - Increment and clear in the same cycle result in 1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench parameters for all scenarios: PD_HOLD=4, STABLE=8, TIMEOUT=32, MCGB=2, MAX_RETRIES=2.
- Release reset, `pll_locked`=1 constant:
  - `pll_powerdown` is 1 for 4 cycles after reset release.
  - `pll_locked_q` rises exactly 4+8+2 cycles plus the synchronizer offset later.
  - `mcgb_rst` falls the same cycle `pll_locked_q` rises.
- `pll_locked`=0 constant:
  - Two timeouts each re-enter PWRDN with `retry_cnt` 1 then 2.
  - The third timeout gives `seq_fail`=1, `pll_powerdown`=1, `retry_cnt`=3.
- While LOCKED, drop `pll_locked` for 3 cycles:
  - `pll_locked_q`=0 two to three cycles later.
  - `lock_lost`=1 and `retry_cnt`=0; re-lock completes.
  - A `clear_sticky` pulse clears `lock_lost`.
- While LOCKED, assert `pll_powerdown_b` for 10 cycles:
  - `pll_powerdown`=1 within 3 cycles and holds until 4 cycles after `req_s` falls.
  - `lock_lost` stays 0.
- In FAIL, pulse `pll_powerdown_a`:
  - Exits FAIL to PWRDN; `seq_fail`=0 and `retry_cnt`=0.
- Lock toggles every 5 cycles in WAIT_LOCK: lock is never accepted (stable <8), and the timeout fires at cycle 32.
- Assert reset mid-MCGB_WAIT: all outputs return to reset values asynchronously.
- With PLL_SEQ_LOSS_COUNT_EN defined: 300 lock losses -> `lock_loss_count`=255.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL power-down / lock-qualification sequencer with bounded lock retries.
// Optional macro PLL_SEQ_LOSS_COUNT_EN adds the lock_loss_count output.
module pll_reset_sequencer #(
  parameter int PD_HOLD_CYCLES      = 100,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MCGB_DELAY_CYCLES   = 16,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       pll_powerdown_a,
  input  logic       pll_powerdown_b,
  input  logic       clear_sticky,
  output logic       pll_powerdown,
  output logic       mcgb_rst,
  output logic       pll_locked_q,
  output logic       lock_lost,
  output logic       seq_fail,
  output logic [1:0] retry_cnt
`ifdef PLL_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  typedef enum logic [2:0] {
    S_PWRDN,
    S_WAIT_LOCK,
    S_MCGB_WAIT,
    S_LOCKED,
    S_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] PD_LD = CNT_W'(PD_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LD = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MG_LD = CNT_W'(MCGB_DELAY_CYCLES - 1);
  localparam logic [31:0]      MAX_R = MAX_RETRIES;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_to, w_to_nxt;
  logic [1:0]       r_retry, w_retry_nxt;
  logic             r_lk_s1, r_lk_s;
  logic             r_req_s1, r_req_s, r_req_d;
  logic             r_pd, r_mcgb, r_lq, r_lost, r_fail;
  logic             w_lost_set;
  logic [2:0]       w_retry_inc;
  logic [1:0]       w_retry_sat;

  assign w_retry_inc = {1'b0, r_retry} + 3'd1;
  assign w_retry_sat = (r_retry == 2'd3) ? 2'd3 : w_retry_inc[1:0];

  // Two-flop synchronizers for raw lock and combined powerdown request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lk_s1  <= 1'b0;
      r_lk_s   <= 1'b0;
      r_req_s1 <= 1'b0;
      r_req_s  <= 1'b0;
      r_req_d  <= 1'b0;
    end else begin
      r_lk_s1  <= pll_locked;
      r_lk_s   <= r_lk_s1;
      r_req_s1 <= pll_powerdown_a | pll_powerdown_b;
      r_req_s  <= r_req_s1;
      r_req_d  <= r_req_s;
    end
  end

  // Next state, counter reloads and retry bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = r_to;
    w_retry_nxt = r_retry;
    w_lost_set  = 1'b0;
    unique case (r_state)
      S_PWRDN: begin
        if (r_req_s) begin
          w_cnt_nxt = PD_LD;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = ST_LD;
          w_to_nxt    = TO_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (r_req_s) begin
          w_state_nxt = S_PWRDN;
          w_cnt_nxt   = PD_LD;
          w_retry_nxt = 2'd0;
        end else if (r_lk_s && r_cnt == '0) begin
          w_state_nxt = S_MCGB_WAIT;
          w_cnt_nxt   = MG_LD;
        end else if (r_to == '0) begin
          w_retry_nxt = w_retry_sat;
          w_cnt_nxt   = PD_LD;
          w_state_nxt = ({29'd0, w_retry_inc} > MAX_R) ? S_FAIL : S_PWRDN;
        end else begin
          w_to_nxt  = r_to - 1'b1;
          w_cnt_nxt = r_lk_s ? r_cnt - 1'b1 : ST_LD;
        end
      end
      S_MCGB_WAIT: begin
        if (r_req_s) begin
          w_state_nxt = S_PWRDN;
          w_cnt_nxt   = PD_LD;
          w_retry_nxt = 2'd0;
        end else if (!r_lk_s) begin
          w_state_nxt = S_PWRDN;
          w_cnt_nxt   = PD_LD;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_LOCKED;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_LOCKED: begin
        if (r_req_s) begin
          w_state_nxt = S_PWRDN;
          w_cnt_nxt   = PD_LD;
          w_retry_nxt = 2'd0;
        end else if (!r_lk_s) begin
          w_state_nxt = S_PWRDN;
          w_cnt_nxt   = PD_LD;
          w_retry_nxt = 2'd0;
          w_lost_set  = 1'b1;
        end
      end
      S_FAIL: begin
        if (r_req_s && !r_req_d) begin
          w_state_nxt = S_PWRDN;
          w_cnt_nxt   = PD_LD;
          w_retry_nxt = 2'd0;
        end
      end
      default: begin
        w_state_nxt = S_PWRDN;
        w_cnt_nxt   = PD_LD;
      end
    endcase
  end

  // State, counters and outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_PWRDN;
      r_cnt   <= PD_LD;
      r_to    <= '0;
      r_retry <= 2'd0;
      r_pd    <= 1'b1;
      r_mcgb  <= 1'b1;
      r_lq    <= 1'b0;
      r_fail  <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_to    <= w_to_nxt;
      r_retry <= w_retry_nxt;
      r_pd    <= (w_state_nxt == S_PWRDN) || (w_state_nxt == S_FAIL);
      r_mcgb  <= (w_state_nxt != S_LOCKED);
      r_lq    <= (w_state_nxt == S_LOCKED);
      r_fail  <= (w_state_nxt == S_FAIL);
      if (w_lost_set)        r_lost <= 1'b1;
      else if (clear_sticky) r_lost <= 1'b0;
    end
  end

  assign pll_powerdown = r_pd;
  assign mcgb_rst      = r_mcgb;
  assign pll_locked_q  = r_lq;
  assign lock_lost     = r_lost;
  assign seq_fail      = r_fail;
  assign retry_cnt     = r_retry;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] r_llc;

  // Saturating lock-loss counter; a loss coinciding with a clear counts as one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_llc <= 8'd0;
    end else if (w_lost_set) begin
      if (clear_sticky)        r_llc <= 8'd1;
      else if (r_llc != 8'hFF) r_llc <= r_llc + 8'd1;
    end else if (clear_sticky) begin
      r_llc <= 8'd0;
    end
  end

  assign lock_loss_count = r_llc;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output-change events
// are queued by stimulus and matched by an independent monitor.
module tb_pll_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_powerdown_a = 1'b0;
  logic       pll_powerdown_b = 1'b0;
  logic       clear_sticky = 1'b0;
  logic       pll_powerdown, mcgb_rst, pll_locked_q;
  logic       lock_lost, seq_fail;
  logic [1:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
`endif

  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  ev_t q[$];

  pll_reset_sequencer #(
    .PD_HOLD_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MCGB_DELAY_CYCLES  (2),
    .MAX_RETRIES        (2),
    .CNT_W              (17)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .pll_powerdown_a(pll_powerdown_a),
    .pll_powerdown_b(pll_powerdown_b),
    .clear_sticky   (clear_sticky),
    .pll_powerdown  (pll_powerdown),
    .mcgb_rst       (mcgb_rst),
    .pll_locked_q   (pll_locked_q),
    .lock_lost      (lock_lost),
    .seq_fail       (seq_fail),
    .retry_cnt      (retry_cnt)
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    .lock_loss_count(lock_loss_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [6:0] mk(input bit pd, input bit mc,
                                    input bit lq, input bit ll,
                                    input bit sf, input logic [1:0] rc);
    return {pd, mc, lq, ll, sf, rc};
  endfunction

  function automatic logic [6:0] outv();
    return {pll_powerdown, mcgb_rst, pll_locked_q, lock_lost,
            seq_fail, retry_cnt};
  endfunction

  task automatic push(input int c, input logic [6:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic waitcyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input string nm, input int lim);
    int n = 0;
    while (q.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d events still pending, required 0",
               nm, q.size());
      q.delete();
    end
  endtask

  task automatic do_reset(input logic lk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_assert++;
    if (outv() !== 7'b1100000) begin
      n_fail++;
      $display("FAIL async_reset: got %b, required %b", outv(), 7'b1100000);
    end
    pll_locked = lk;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic do_drop();
    int c;
    c = cyc;
    pll_locked = 1'b0;
    push(c + 3,  mk(1, 1, 0, 1, 0, 2'd0));
    push(c + 7,  mk(0, 1, 0, 1, 0, 2'd0));
    push(c + 17, mk(0, 0, 1, 1, 0, 2'd0));
    waitcyc(c + 3);
    pll_locked = 1'b1;
    drain("lock_drop", 40);
  endtask

  // Monitor: every output change outside reset must match the queue head
  initial begin
    logic [6:0] prev, cur;
    ev_t e;
    prev = 7'b1100000;
    forever begin
      @(negedge clk);
      cur = outv();
      if (reset) begin
        prev = cur;
      end else if (cur !== prev) begin
        n_assert++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: cyc %0d got %b, none required",
                   cyc, cur);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.v !== cur) begin
            n_fail++;
            $display("FAIL event: cyc %0d got %b, required cyc %0d %b",
                     cyc, cur, e.cyc, e.v);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int c;

    // Clean start with constant lock
    do_reset(1'b1);
    push(4,  mk(0, 1, 0, 0, 0, 2'd0));
    push(14, mk(0, 0, 1, 0, 0, 2'd0));
    drain("clean_lock", 40);

    // Consumer b powerdown request while LOCKED
    c = cyc;
    pll_powerdown_b = 1'b1;
    push(c + 3,  mk(1, 1, 0, 0, 0, 2'd0));
    push(c + 16, mk(0, 1, 0, 0, 0, 2'd0));
    push(c + 26, mk(0, 0, 1, 0, 0, 2'd0));
    waitcyc(c + 10);
    pll_powerdown_b = 1'b0;
    drain("req_b", 40);

    // No lock: retries exhaust into FAIL
    do_reset(1'b0);
    push(4,   mk(0, 1, 0, 0, 0, 2'd0));
    push(36,  mk(1, 1, 0, 0, 0, 2'd1));
    push(40,  mk(0, 1, 0, 0, 0, 2'd1));
    push(72,  mk(1, 1, 0, 0, 0, 2'd2));
    push(76,  mk(0, 1, 0, 0, 0, 2'd2));
    push(108, mk(1, 1, 0, 0, 1, 2'd3));
    drain("retries", 140);

    // Exit FAIL via consumer a, toggling lock times out, then lock
    c = cyc;
    pll_powerdown_a = 1'b1;
    push(c + 3,  mk(1, 1, 0, 0, 0, 2'd0));
    push(c + 7,  mk(0, 1, 0, 0, 0, 2'd0));
    push(c + 39, mk(1, 1, 0, 0, 0, 2'd1));
    push(c + 43, mk(0, 1, 0, 0, 0, 2'd1));
    push(c + 53, mk(0, 0, 1, 0, 0, 2'd1));
    waitcyc(c + 1);
    pll_powerdown_a = 1'b0;
    waitcyc(c + 3);
    for (int k = 0; k < 36; k++) begin
      if (k % 5 == 0) pll_locked = ~pll_locked;
      @(negedge clk);
    end
    pll_locked = 1'b1;
    drain("fail_exit", 40);

    // Lock loss while LOCKED clears retries, sets lock_lost, relocks
    do_drop();
`ifdef PLL_SEQ_LOSS_COUNT_EN
    n_assert++;
    if (lock_loss_count !== 8'd1) begin
      n_fail++;
      $display("FAIL loss_count_one: got %0d, required 1", lock_loss_count);
    end
`endif

    // clear_sticky clears lock_lost
    c = cyc;
    clear_sticky = 1'b1;
    push(c + 1, mk(0, 0, 1, 0, 0, 2'd0));
    waitcyc(c + 1);
    clear_sticky = 1'b0;
    drain("clear_sticky", 10);

    // Reset asserted mid-MCGB_WAIT
    do_reset(1'b1);
    push(4, mk(0, 1, 0, 0, 0, 2'd0));
    drain("pre_mcgb", 20);
    waitcyc(12);
    do_reset(1'b1);
    push(4,  mk(0, 1, 0, 0, 0, 2'd0));
    push(14, mk(0, 0, 1, 0, 0, 2'd0));
    drain("relock", 40);

`ifdef PLL_SEQ_LOSS_COUNT_EN
    for (int i = 0; i < 300; i++) do_drop();
    n_assert++;
    if (lock_loss_count !== 8'd255) begin
      n_fail++;
      $display("FAIL loss_count_sat: got %0d, required 255",
               lock_loss_count);
    end
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
